// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS sequencer.
interface mips_multicycle_control_if;
   logic        run;
   logic [5:0]  op;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        mem_to_reg;
   logic        reg_dst;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  pc_source;
   logic [3:0]  state;
   logic        instr_done;
   logic [31:0] retired;
   logic        fault;

   // Sequencer side
   modport master (
      input  run, op, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, instr_done, retired, fault
   );

   // Datapath / memory side
   modport slave (
      output run, op, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, instr_done, retired, fault
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer with memory-ready handshake and stall watchdog.
module mips_multicycle_control #(
   parameter int unsigned STALL_LIMIT = 15
) (
   input logic                        clk,
   input logic                        rst_n,
   mips_multicycle_control_if.master  bus
);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned RET_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_FAULT  = 4'd10
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   stall_q;
   logic [RET_W-1:0]   retired_q;
   logic               mem_state_c, stall_hit_c, complete_c;

   logic pc_write_cond_q, i_or_d_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic reg_dst_q, reg_write_q, alu_src_a_q, done_q, fault_q;
   logic [1:0] alu_src_b_q, alu_op_q, pc_source_q;

   logic pc_write_cond_d, i_or_d_d, mem_read_d, mem_write_d, mem_to_reg_d;
   logic reg_dst_d, reg_write_d, alu_src_a_d, done_d, fault_d;
   logic [1:0] alu_src_b_d, alu_op_d, pc_source_d;

   // Next-state: instruction sequencing, completion and watchdog trap
   always_comb begin
      state_d     = state_q;
      mem_state_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      stall_hit_c = mem_state_c && !bus.mem_ready && (stall_q == CNT_W'(STALL_LIMIT));
      complete_c  = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEMWR) && bus.mem_ready);
      unique case (state_q)
         S_IDLE:   if (bus.run) state_d = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               default:      state_d = S_FAULT;
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_EXEC:   state_d = S_RWB;
         S_MEMWR, S_MEMWB, S_RWB, S_BRANCH, S_FAULT: state_d = state_q;
         default:  state_d = S_FAULT;
      endcase
      if (complete_c) state_d = bus.run ? S_FETCH : S_IDLE;
      if (stall_hit_c) state_d = S_FAULT;
   end

   // Moore output decode of the state being entered, so outputs can be registered
   always_comb begin
      pc_write_cond_d = 1'b0;
      i_or_d_d        = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
      reg_dst_d       = 1'b0;
      reg_write_d     = 1'b0;
      alu_src_a_d     = 1'b0;
      done_d          = 1'b0;
      fault_d         = 1'b0;
      alu_src_b_d     = 2'b00;
      alu_op_d        = 2'b00;
      pc_source_d     = 2'b00;
      case (state_d)
         S_FETCH:  begin mem_read_d = 1'b1; alu_src_b_d = 2'b01; end
         S_DECODE: alu_src_b_d = 2'b11;
         S_MEMADR: begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; end
         S_MEMRD:  begin mem_read_d = 1'b1; i_or_d_d = 1'b1; end
         S_MEMWB:  begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; done_d = 1'b1; end
         S_MEMWR:  begin mem_write_d = 1'b1; i_or_d_d = 1'b1; end
         S_EXEC:   begin alu_src_a_d = 1'b1; alu_op_d = 2'b10; end
         S_RWB:    begin reg_write_d = 1'b1; reg_dst_d = 1'b1; done_d = 1'b1; end
         S_BRANCH: begin
            alu_src_a_d     = 1'b1;
            alu_op_d        = 2'b01;
            pc_write_cond_d = 1'b1;
            pc_source_d     = 2'b01;
            done_d          = 1'b1;
         end
         S_FAULT:  fault_d = 1'b1;
         default:  ;
      endcase
   end

   // State, watchdog, retired counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         stall_q         <= '0;
         retired_q       <= '0;
         pc_write_cond_q <= 1'b0;
         i_or_d_q        <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         reg_dst_q       <= 1'b0;
         reg_write_q     <= 1'b0;
         alu_src_a_q     <= 1'b0;
         done_q          <= 1'b0;
         fault_q         <= 1'b0;
         alu_src_b_q     <= 2'b00;
         alu_op_q        <= 2'b00;
         pc_source_q     <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            stall_q <= '0;
         else if (mem_state_c && !bus.mem_ready)
            stall_q <= stall_q + CNT_W'(1);
         if (complete_c) retired_q <= retired_q + RET_W'(1);
         pc_write_cond_q <= pc_write_cond_d;
         i_or_d_q        <= i_or_d_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_to_reg_q    <= mem_to_reg_d;
         reg_dst_q       <= reg_dst_d;
         reg_write_q     <= reg_write_d;
         alu_src_a_q     <= alu_src_a_d;
         done_q          <= done_d;
         fault_q         <= fault_d;
         alu_src_b_q     <= alu_src_b_d;
         alu_op_q        <= alu_op_d;
         pc_source_q     <= pc_source_d;
      end
   end

   // Fetch handshake strobes and store completion follow mem_ready in the same cycle
   assign bus.pc_write      = (state_q == S_FETCH) && bus.mem_ready;
   assign bus.ir_write      = (state_q == S_FETCH) && bus.mem_ready;
   assign bus.instr_done    = done_q || ((state_q == S_MEMWR) && bus.mem_ready);
   assign bus.pc_write_cond = pc_write_cond_q;
   assign bus.i_or_d        = i_or_d_q;
   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_to_reg    = mem_to_reg_q;
   assign bus.reg_dst       = reg_dst_q;
   assign bus.reg_write     = reg_write_q;
   assign bus.alu_src_a     = alu_src_a_q;
   assign bus.alu_src_b     = alu_src_b_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.pc_source     = pc_source_q;
   assign bus.state         = state_q;
   assign bus.retired       = retired_q;
   assign bus.fault         = fault_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: path-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_mips_multicycle_control;
   localparam int unsigned STALL_LIMIT = 15;
   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BAD = 6'b111111;
   localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef logic [3:0] st_t;

   // Vector bits: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], instr_done, fault
   localparam logic [17:0] ROM [11] = '{
      18'h00000,   // IDLE
      18'h04040,   // FETCH: mem_read, alu_src_b=01
      18'h000C0,   // DECODE: alu_src_b=11
      18'h00180,   // MEMADR: alu_src_a, alu_src_b=10
      18'h0C000,   // MEMRD: i_or_d, mem_read
      18'h00A00,   // MEMWB: mem_to_reg, reg_write
      18'h0A000,   // MEMWR: i_or_d, mem_write
      18'h00120,   // EXEC: alu_src_a, alu_op=10
      18'h00600,   // RWB: reg_dst, reg_write
      18'h10114,   // BRANCH: pc_write_cond, alu_src_a, alu_op=01, pc_source=01
      18'h00001    // FAULT
   };
   localparam logic [17:0] FETCH_READY = 18'h21000;  // pc_write | ir_write

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] op = 6'd0;

   int n_checks = 0;
   int n_pass = 0;
   int done_cnt = 0;
   logic rec = 1'b0;
   st_t trace[$];

   mips_multicycle_control_if bus ();
   assign bus.run       = run;
   assign bus.op        = op;
   assign bus.zero      = zero;
   assign bus.mem_ready = mem_ready;

   mips_multicycle_control #(.STALL_LIMIT(STALL_LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: each instruction is a list of states still to visit
   st_t         m_state = 4'd0;
   int unsigned m_wait = 0;
   logic [31:0] m_retired = 32'd0;
   st_t         path[$];

   function automatic logic is_mem(input st_t s);
      return (s == 4'd1) || (s == 4'd4) || (s == 4'd6);
   endfunction

   function automatic logic last_step();
      return (path.size() == 0) && (m_state != 4'd0) && (m_state != 4'd2) && (m_state != 4'd10);
   endfunction

   task automatic model_step();
      if (m_state == 4'd10) return;
      if (m_state == 4'd0) begin
         if (run) begin m_state = 4'd1; m_wait = 0; path = '{4'd2}; end
         return;
      end
      if (is_mem(m_state) && !mem_ready) begin
         if (m_wait == STALL_LIMIT) begin m_state = 4'd10; path.delete(); end
         else m_wait++;
         return;
      end
      if (m_state == 4'd2) begin
         case (op)
            OP_LW:   path = '{4'd3, 4'd4, 4'd5};
            OP_SW:   path = '{4'd3, 4'd6};
            OP_R:    path = '{4'd7, 4'd8};
            OP_BEQ:  path = '{4'd9};
            default: path = '{4'd10};
         endcase
      end
      if (path.size() == 0) begin
         m_retired = m_retired + 32'd1;
         if (run) begin m_state = 4'd1; path = '{4'd2}; end
         else m_state = 4'd0;
      end else begin
         m_state = path.pop_front();
      end
      m_wait = 0;
   endtask

   function automatic logic [17:0] exp_vec();
      logic [17:0] v;
      v = ROM[m_state];
      if ((m_state == 4'd1) && mem_ready) v = v | FETCH_READY;
      if (last_step() && (!is_mem(m_state) || mem_ready)) v[1] = 1'b1;
      return v;
   endfunction

   function automatic logic [17:0] dut_vec();
      return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.fault};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", nm, $time, act, exp);
   endtask

   task automatic check_trace(input string nm, input st_t exp[$]);
      int bad;
      bad = -1;
      n_checks++;
      if (trace.size() != exp.size()) bad = 0;
      else foreach (exp[i]) if ((bad < 0) && (trace[i] !== exp[i])) bad = i;
      if (bad < 0) n_pass++;
      else if (trace.size() != exp.size())
         $display("FAIL %s: trace length %0d, required %0d", nm, trace.size(), exp.size());
      else
         $display("FAIL %s: cycle %0d state %0d, required %0d", nm, bad, trace[bad], exp[bad]);
   endtask

   // Model advance on the active edge (and asynchronously on reset)
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_state = 4'd0; m_wait = 0; m_retired = 32'd0; path.delete();
      end else begin
         model_step();
      end
   end

   // Compare every cycle away from the active edge
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (rec) begin
            trace.push_back(bus.state);
            if (bus.instr_done) done_cnt++;
         end
         check("cycle_state_ctrl", {bus.state, dut_vec()}, {m_state, exp_vec()});
         check("cycle_retired", bus.retired, m_retired);
      end
   end

   // Drive one scenario: per-cycle run/mem_ready from masks, op switches at cycle sw
   task automatic play(input logic [5:0] op_a, input logic [5:0] op_b, input int sw, input int n,
                       input logic [63:0] run_m, input logic [63:0] rdy_m);
      trace.delete();
      done_cnt = 0;
      rec = 1'b1;
      for (int i = 0; i < n; i++) begin
         op        = (i < sw) ? op_a : op_b;
         run       = run_m[i];
         mem_ready = rdy_m[i];
         zero      = i[0];
         @(posedge clk); #1;
      end
      rec = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      run = 1'b0;
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check({nm, "_state"}, bus.state, 64'd0);
      check({nm, "_outputs"}, dut_vec(), 64'd0);
      check({nm, "_retired"}, bus.retired, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      st_t e[$];
      #1 rst_n = 1'b0;
      #1;
      check("reset_state", bus.state, 64'd0);
      check("reset_outputs", dut_vec(), 64'd0);
      check("reset_retired", bus.retired, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // R-type, run dropped during EXEC: finishes then idles
      play(OP_R, OP_R, 99, 6, 64'h7, ALL1);
      e = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd0};
      check_trace("rtype_states", e);
      check("rtype_done_pulses", done_cnt, 64'd1);
      check("rtype_retired", bus.retired, 64'd1);

      // LW with three wait cycles in MEMRD
      play(OP_LW, OP_LW, 99, 10, 64'h1, 64'hFFFF_FFFF_FFFF_FF8F);
      e = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0};
      check_trace("lw_wait_states", e);
      check("lw_retired", bus.retired, 64'd2);

      // SW then BEQ back to back
      play(OP_SW, OP_BEQ, 5, 9, 64'h11, ALL1);
      e = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd1, 4'd2, 4'd9, 4'd0};
      check_trace("sw_beq_states", e);
      check("sw_beq_done_pulses", done_cnt, 64'd2);
      check("sw_beq_retired", bus.retired, 64'd4);

      // Illegal opcode traps and stays trapped while run toggles
      play(OP_BAD, OP_BAD, 99, 8, 64'hAB, ALL1);
      e = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10};
      check_trace("illegal_states", e);
      check("illegal_fault", bus.fault, 64'd1);
      do_reset("illegal_clear");

      // Fetch stalls forever: faults after the limit cycle
      play(OP_R, OP_R, 99, 19, 64'h1, 64'h0);
      e = '{4'd0};
      for (int i = 0; i < 16; i++) e.push_back(4'd1);
      e.push_back(4'd10);
      e.push_back(4'd10);
      check_trace("stall_fault_states", e);
      check("stall_fault_flag", bus.fault, 64'd1);
      do_reset("stall_clear");

      // Ready arrives exactly in the limit cycle: no fault
      play(OP_R, OP_R, 99, 21, 64'h1, 64'hFFFF_FFFF_FFFF_0000);
      e = '{4'd0};
      for (int i = 0; i < 16; i++) e.push_back(4'd1);
      e.push_back(4'd2);
      e.push_back(4'd7);
      e.push_back(4'd8);
      e.push_back(4'd0);
      check_trace("limit_ready_states", e);
      check("limit_ready_no_fault", bus.fault, 64'd0);
      check("limit_ready_retired", bus.retired, 64'd1);

      // Reset asserted mid-cycle while waiting in MEMRD
      play(OP_LW, OP_LW, 99, 5, 64'h1, 64'h0F);
      check("pre_reset_memrd", bus.state, 64'd4);
      check("pre_reset_mem_read", bus.mem_read, 64'd1);
      #2;
      do_reset("midread_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
